// File: rtl/mod_counter_ctrl.sv
// mod_counter_ctrl: start/pause/resume/stop sequencing around a loadable mod-N counter
// that runs a programmable number of full wraps and then reports done.
// Optional feature: define MODCTRL_UPDOWN_EN to add a Down input for down-counting.
module mod_counter_ctrl #(
   parameter int unsigned WIDTH       = 3,
   parameter int unsigned DEFAULT_MOD = 5,
   parameter int unsigned REPS_W      = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stop,
   input  logic              Pause,
   input  logic              Load,
`ifdef MODCTRL_UPDOWN_EN
   input  logic              Down,
`endif
   input  logic [WIDTH-1:0]  ModIn,
   input  logic [REPS_W-1:0] RepsIn,
   output logic [WIDTH-1:0]  Count,
   output logic              Tc,
   output logic              Busy,
   output logic              Done,
   output logic [1:0]        State
);

   // Modulus needs one extra bit so DEFAULT_MOD may equal 2^WIDTH.
   localparam int unsigned MW = WIDTH + 1;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic [MW-1:0]     mod_q, mod_d;
   logic [REPS_W-1:0] reps_q, reps_d;
   logic [REPS_W-1:0] left_q, left_d;

   logic              down;
   logic [MW-1:0]     mod_m1;
   logic [WIDTH-1:0]  top;
   logic              at_wrap;

`ifdef MODCTRL_UPDOWN_EN
   assign down = Down;
`else
   assign down = 1'b0;
`endif

   assign mod_m1  = mod_q - MW'(1);
   assign top     = mod_m1[WIDTH-1:0];
   // Wrap point is the last value in the current counting direction.
   assign at_wrap = down ? (count_q == '0) : ({1'b0, count_q} == mod_m1);

   // State and datapath registers, async active-high reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         count_q <= '0;
         mod_q   <= MW'(DEFAULT_MOD);
         reps_q  <= '0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mod_q   <= mod_d;
         reps_q  <= reps_d;
         left_q  <= left_d;
      end
   end

   // Next-state and counter update; priority Stop > Start > Pause > Load.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mod_d   = mod_q;
      reps_d  = reps_q;
      left_d  = left_q;
      if (Stop) begin
         state_d = StIdle;
         count_d = '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (Start) begin
                  state_d = StRun;
                  left_d  = reps_q;
                  count_d = down ? top : '0;
               end else if (Load) begin
                  // Moduli below 2 are meaningless, clamp them.
                  mod_d  = ({1'b0, ModIn} < MW'(2)) ? MW'(2) : {1'b0, ModIn};
                  reps_d = RepsIn;
               end
            end
            StRun: begin
               if (Pause) begin
                  state_d = StPause;
               end else begin
                  if (at_wrap) begin
                     count_d = down ? top : '0;
                  end else if (down) begin
                     count_d = count_q - WIDTH'(1);
                  end else begin
                     count_d = count_q + WIDTH'(1);
                  end
                  // reps_q == 0 means free-running: no decrement, never done.
                  if (at_wrap && (reps_q != '0)) begin
                     left_d = left_q - REPS_W'(1);
                     if (left_q == REPS_W'(1)) begin
                        state_d = StDone;
                        count_d = '0;
                     end
                  end
               end
            end
            StPause: begin
               if (Start) begin
                  state_d = StRun;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Output decodes, purely from registered state.
   always_comb begin
      Count = count_q;
      Tc    = (state_q == StRun) && at_wrap;
      Busy  = (state_q == StRun) || (state_q == StPause);
      Done  = (state_q == StDone);
      State = state_q;
   end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Randomized bench for mod_counter_ctrl against a behavioural model.
module tb_mod_counter_ctrl;

   localparam int WIDTH  = 3;
   localparam int REPS_W = 4;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

   logic              Clock;
   logic              Reset;
   logic              Start, Stop, Pause, Load;
   logic              Down;
   logic [WIDTH-1:0]  ModIn;
   logic [REPS_W-1:0] RepsIn;
   logic [WIDTH-1:0]  Count;
   logic              Tc, Busy, Done;
   logic [1:0]        State;

   int n_vec;
   int n_err;

   // Model state
   int m_st, m_cnt, m_mod, m_reps, m_left;

   mod_counter_ctrl #(.WIDTH(WIDTH), .DEFAULT_MOD(5), .REPS_W(REPS_W)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .Stop   (Stop),
      .Pause  (Pause),
      .Load   (Load),
`ifdef MODCTRL_UPDOWN_EN
      .Down   (Down),
`endif
      .ModIn  (ModIn),
      .RepsIn (RepsIn),
      .Count  (Count),
      .Tc     (Tc),
      .Busy   (Busy),
      .Done   (Done),
      .State  (State)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic bit down_active();
`ifdef MODCTRL_UPDOWN_EN
      return Down;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_st = S_IDLE; m_cnt = 0; m_mod = 5; m_reps = 0; m_left = 0;
   endtask

   // One clock edge of behaviour, described as modular counting over the
   // configured modulus and a count of remaining wraps.
   task automatic model_step();
      bit dn;
      int nxt;
      bit wrapped;
      dn = down_active();
      if (Stop) begin
         m_st = S_IDLE; m_cnt = 0;
      end else if (m_st == S_IDLE || m_st == S_DONE) begin
         if (Start) begin
            m_st = S_RUN; m_left = m_reps; m_cnt = dn ? m_mod - 1 : 0;
         end else if (Load) begin
            m_mod  = (int'(ModIn) < 2) ? 2 : int'(ModIn);
            m_reps = int'(RepsIn);
         end
      end else if (m_st == S_RUN) begin
         if (Pause) begin
            m_st = S_PAUSE;
         end else begin
            nxt     = dn ? (m_cnt + m_mod - 1) % m_mod : (m_cnt + 1) % m_mod;
            wrapped = dn ? (m_cnt == 0) : (nxt == 0);
            m_cnt   = nxt;
            if (wrapped && m_reps != 0) begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_st = S_DONE; m_cnt = 0;
               end
            end
         end
      end else begin
         if (Start) m_st = S_RUN;
      end
   endtask

   task automatic check_outputs();
      int tc_exp;
      tc_exp = (m_st == S_RUN) && (m_cnt == (down_active() ? 0 : m_mod - 1));
      check("Count", int'(Count), m_cnt);
      check("Tc",    int'(Tc),    tc_exp);
      check("Busy",  int'(Busy),  int'(m_st == S_RUN || m_st == S_PAUSE));
      check("Done",  int'(Done),  int'(m_st == S_DONE));
      check("State", int'(State), m_st);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      Reset = 1'b1;
      Start = 0; Stop = 0; Pause = 0; Load = 0; Down = 0;
      ModIn = '0; RepsIn = '0;
      model_reset();
      #12;
      check_outputs();
      @(negedge Clock);
      Reset = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge Clock);
         check_outputs();
         if ($urandom_range(0, 299) == 0) begin
            // Asynchronous reset mid-operation takes effect without a clock edge.
            Reset = 1'b1;
            #1;
            model_reset();
            check_outputs();
            @(negedge Clock);
            Reset = 1'b0;
            check_outputs();
         end
         Start  = ($urandom_range(0, 5) == 0);
         Stop   = ($urandom_range(0, 29) == 0);
         Pause  = ($urandom_range(0, 9) == 0);
         Load   = ($urandom_range(0, 4) == 0);
         ModIn  = WIDTH'($urandom_range(0, 7));
         RepsIn = REPS_W'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) Down = ~Down;
         @(posedge Clock);
         model_step();
      end
      @(negedge Clock);
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mod_counter_ctrl.md
Name: mod_counter_ctrl

Overview:
- Sequencing controller wrapped around a programmable mod-N counter datapath.
- FSM starts, pauses, resumes and stops the counter, holds a loadable modulus, and runs a programmable number of full cycles before signalling completion.
- Used by higher-level logic (display scanners, timers) that needs "count N cycles of mod-M, then report done" without re-implementing counter control.

Parameters:
- WIDTH, 3, counter and modulus width in bits.
- DEFAULT_MOD, 5, modulus value after reset; must satisfy 2 <= DEFAULT_MOD <= 2^WIDTH.
- REPS_W, 4, width of the repetition-count register.

Ports:
- Clock  input  1  single system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin a run from IDLE/DONE; resume from PAUSE.
- Stop  input  1  abort to IDLE from any state.
- Pause  input  1  freeze counting while in RUN.
- Load  input  1  capture ModIn/RepsIn into the config registers.
- ModIn  input  WIDTH  new modulus.
- RepsIn  input  REPS_W  number of full wraps per run; 0 = run forever.
- Count  output  WIDTH  current counter value.
- Tc  output  1  terminal-count flag: high while RUN and Count == mod_r-1.
- Busy  output  1  high in RUN or PAUSE.
- Done  output  1  high in DONE.
- State  output  2  FSM state encoding.

Behaviour:
- Reset (async): State=IDLE, Count=0, mod_r=DEFAULT_MOD, reps_r=0, reps_left=0, Tc=0, Busy=0, Done=0.
- FSM encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- Input priority, evaluated each edge: Stop > Start > Pause > Load.
- Stop in any state: next state IDLE, Count=0. Takes effect even on the same cycle as a wrap; no Done is produced.
- IDLE or DONE:
  - Start: Count=0, reps_left=reps_r, go to RUN. The first increment occurs on the following edge.
  - Load without Start: mod_r=ModIn, reps_r=RepsIn. ModIn values 0 or 1 clamp to 2.
  - Load with Start on the same edge: Start wins and uses the old config; Load is dropped.
- Load while in RUN or PAUSE: ignored; config is unchanged.
- RUN, each edge without Stop or Pause:
  - If Count == mod_r-1: Count=0 (wrap).
  - Otherwise: Count+1.
  - On a wrap with reps_r != 0: reps_left decrements. If reps_left was 1, go to DONE with Count=0.
  - reps_r == 0: counts indefinitely, never enters DONE.
- Start while in RUN: ignored.
- Pause in RUN: go to PAUSE, Count holds; a wrap scheduled for that edge does not happen.
- PAUSE:
  - Count, reps_left and Tc are frozen; Tc is forced 0.
  - Start: return to RUN; counting continues from the held value.
  - Pause has no further effect.
- DONE: Done=1, Count=0. Holds until Start (new run) or Stop.
- Tc, Busy, Done and State are combinational decodes of registered state; there is no extra latency.
- Count always stays within 0..mod_r-1.
- Reset asserted mid-run returns all state immediately to reset values.

Optional Feature:
- Macro: MODCTRL_UPDOWN_EN.
- When defined:
  - Adds input port Down (1 bit), sampled every RUN cycle.
  - Down=1 counts mod_r-1 → … → 0 → mod_r-1. The wrap occurs at Count == 0, and Tc decodes Count == 0.
  - Start loads Count=mod_r-1 if Down=1, else 0.
  - Toggling Down mid-run changes direction on the next edge without reloading Count.
- When not defined: no Down port; up-count only, exactly as above.

Test Plan:
- Reset, then Start with defaults (mod 5, reps 0) → Count 0,1,2,3,4,0,1…; Tc high only when Count=4; Busy=1; Done never asserts.
- Load ModIn=3, RepsIn=2 in IDLE, then Start → Count 0,1,2,0,1,2,0; DONE entered on the second wrap; Done=1, Busy=0, Count=0.
- RUN mod 5 at Count=2: Pause for 3 cycles, then Start → Count stays 2 with Tc=0 during PAUSE, then resumes 3,4,0.
- Stop and Pause asserted together at Count=4 → IDLE, Count=0; no wrap-driven reps_left decrement and no Done.
- Load ModIn=1 in IDLE, then Start → behaves as mod 2: 0,1,0,1. Load ModIn=7 during RUN → ignored; modulus stays 2.
- With MODCTRL_UPDOWN_EN, mod 5, Down=1, Start → Count 4,3,2,1,0,4 with Tc at 0; set Down=0 at Count=2 → 3,4,0.
